// File: rtl/ps2_bus_pkg.sv
// ps2_bus_pkg: register map, STATUS bit positions and FSM
// encoding shared by the PS/2 68000 bus controller.
package ps2_bus_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_RXV = 0;
  localparam int ST_TXB = 1;
  localparam int ST_OVR = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ACK
  } state_t;

endpackage

// File: rtl/ps2_bus_ctrl_sync_ff.sv
// sync_ff: STAGES-deep single-bit synchronizer with a
// synchronous reset to a selectable idle level.
module sync_ff #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sh;

  always_ff @(posedge clk) begin
    if (reset) r_sh <= {STAGES{RST_VAL}};
    else       r_sh <= {r_sh[STAGES-2:0], d};
  end

  assign q = r_sh[STAGES-1];

endmodule

// File: rtl/ps2_bus_ctrl.sv
// ps2_bus_ctrl: 68000 bus-cycle sequencer for the PS/2 block.
// Optional IRQ_EN macro builds the interrupt request logic.
module ps2_bus_ctrl
  import ps2_bus_pkg::*;
#(
  parameter int WAIT_STATES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       ds_n,
  input  logic       rw,
  input  logic [1:0] addr,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic       dtack_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_pop,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_busy,
  output logic [7:0] ctrl,
  output logic       irq
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic       w_cs_s, w_ds_s, w_rw_s, w_strb;
  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic [1:0] r_addr;
  logic       r_rw;
  logic [7:0] r_din;

  logic [7:0] r_d_out, r_tx_data, r_ctrl;
  logic       r_d_oe, r_dtack_n, r_rx_pop;
  logic       r_tx_wr, r_tx_ovr;

  logic [7:0] w_status, w_d_out, w_tx_data, w_ctrl;
  logic       w_d_oe, w_dtack_n, w_rx_pop;
  logic       w_tx_wr, w_tx_ovr;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .reset(reset), .d(cs_n), .q(w_cs_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ds (
    .clk(clk), .reset(reset), .d(ds_n), .q(w_ds_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rw (
    .clk(clk), .reset(reset), .d(rw), .q(w_rw_s)
  );

  assign w_strb = !w_cs_s && !w_ds_s;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_strb) w_next = S_WAIT;
      S_WAIT: begin
        if (!w_strb)          w_next = S_IDLE;
        else if (r_cnt == '0) w_next = S_ACCESS;
      end
      S_ACCESS: w_next = S_ACK;
      S_ACK:    if (!w_strb) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_status         = '0;
    w_status[ST_RXV] = rx_valid;
    w_status[ST_TXB] = tx_busy;
    w_status[ST_OVR] = r_tx_ovr;
    w_d_out   = r_d_out;
    w_rx_pop  = 1'b0;
    w_tx_wr   = 1'b0;
    w_tx_data = r_tx_data;
    w_ctrl    = r_ctrl;
    w_tx_ovr  = r_tx_ovr;
    w_dtack_n = (w_next != S_ACK);
    w_d_oe    = (w_next == S_ACK) && r_rw;
    if (r_state == S_ACCESS) begin
      unique case (1'b1)
        r_rw && (r_addr == REG_DATA): begin
          w_d_out  = rx_valid ? rx_data : 8'h00;
          w_rx_pop = rx_valid;
        end
        r_rw && (r_addr == REG_STATUS): begin
          w_d_out  = w_status;
          w_tx_ovr = 1'b0;
        end
        r_rw && (r_addr == REG_CTRL): w_d_out = r_ctrl;
        r_rw && (r_addr == REG_RSVD): w_d_out = 8'h00;
        !r_rw && (r_addr == REG_DATA): begin
          // A write while busy is dropped and flagged.
          if (tx_busy) begin
            w_tx_ovr = 1'b1;
          end else begin
            w_tx_data = r_din;
            w_tx_wr   = 1'b1;
          end
        end
        !r_rw && (r_addr == REG_CTRL): w_ctrl = r_din;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_addr    <= REG_DATA;
      r_rw      <= 1'b1;
      r_din     <= '0;
      r_d_out   <= '0;
      r_d_oe    <= 1'b0;
      r_dtack_n <= 1'b1;
      r_rx_pop  <= 1'b0;
      r_tx_wr   <= 1'b0;
      r_tx_data <= '0;
      r_ctrl    <= '0;
      r_tx_ovr  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_next == S_WAIT) begin
        r_cnt  <= WS;
        r_addr <= addr;
        r_rw   <= w_rw_s;
        r_din  <= d_in;
      end else if (r_state == S_WAIT && w_next == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_d_out   <= w_d_out;
      r_d_oe    <= w_d_oe;
      r_dtack_n <= w_dtack_n;
      r_rx_pop  <= w_rx_pop;
      r_tx_wr   <= w_tx_wr;
      r_tx_data <= w_tx_data;
      r_ctrl    <= w_ctrl;
      r_tx_ovr  <= w_tx_ovr;
    end
  end

`ifdef IRQ_EN
  logic r_irq;

  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else r_irq <= (r_ctrl[0] & rx_valid) |
                  (r_ctrl[1] & r_tx_ovr);
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign d_out   = r_d_out;
  assign d_oe    = r_d_oe;
  assign dtack_n = r_dtack_n;
  assign rx_pop  = r_rx_pop;
  assign tx_wr   = r_tx_wr;
  assign tx_data = r_tx_data;
  assign ctrl    = r_ctrl;

endmodule

// File: tb/tb_ps2_bus_ctrl.sv
// tb_ps2_bus_ctrl: randomized bus cycles against a
// transaction-level model of the register map.
module tb_ps2_bus_ctrl;

  localparam int WS  = 1;
  localparam int SS  = 2;
  localparam int LAT = SS + WS + 2;

  logic       clk = 1'b0;
  logic       reset, cs_n, ds_n, rw;
  logic [1:0] addr;
  logic [7:0] d_in, d_out, rx_data, tx_data, ctrl;
  logic       d_oe, dtack_n, rx_valid, rx_pop;
  logic       tx_wr, tx_busy, irq;

  ps2_bus_ctrl #(.WAIT_STATES(WS), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .cs_n(cs_n), .ds_n(ds_n),
    .rw(rw), .addr(addr), .d_in(d_in), .d_out(d_out),
    .d_oe(d_oe), .dtack_n(dtack_n), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_pop(rx_pop),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_busy(tx_busy),
    .ctrl(ctrl), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];
  logic [7:0] m_ctrl = 8'h00;
  logic [7:0] m_txd  = 8'h00;
  bit         m_ovr  = 1'b0;

  bit         chk_ack  = 1'b0;
  bit         chk_idle = 1'b0;
  bit         exp_rd   = 1'b0;
  logic [7:0] exp_dout = 8'h00;
  logic [7:0] got_dout = 8'h00;
  int         last_lat = 0;
  int         n_pop = 0;
  int         n_wr  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic bit irq_exp();
    return (m_ctrl[0] && (q.size() > 0)) ||
           (m_ctrl[1] && m_ovr);
  endfunction

  task automatic rx_update();
    rx_valid = (q.size() > 0);
    rx_data  = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  // Receiver model: drops its head byte after a pop pulse.
  always @(posedge clk) begin
    if (rx_pop === 1'b1) begin
      #1;
      if (q.size() > 0) void'(q.pop_front());
      rx_update();
    end
  end

  always @(negedge clk) begin
    if (rx_pop === 1'b1) n_pop++;
    if (tx_wr === 1'b1)  n_wr++;
    if (chk_ack) begin
      got_dout = d_out;
      chk("ack_dtack", dtack_n, 0);
      chk("ack_doe", d_oe, exp_rd);
      if (exp_rd) chk("ack_dout", d_out, exp_dout);
      chk("ack_txdata", tx_data, m_txd);
      chk("ack_ctrl", ctrl, m_ctrl);
    end
    if (chk_idle) begin
      chk("idle_dtack", dtack_n, 1);
      chk("idle_doe", d_oe, 0);
`ifdef IRQ_EN
      chk("idle_irq", irq, irq_exp());
`endif
    end
`ifndef IRQ_EN
    if (!reset) chk("irq_off", irq, 0);
`endif
  end

  task automatic begin_cycle(input bit r,
                             input logic [1:0] a,
                             input logic [7:0] d,
                             output int lat);
    cs_n = 1'b0; ds_n = 1'b0;
    rw = r; addr = a; d_in = d;
    lat = 0;
    @(posedge clk); #1;
    while (dtack_n !== 1'b0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic end_cycle();
    int k;
    k = 0;
    cs_n = 1'b1; ds_n = 1'b1;
    while (dtack_n !== 1'b1 && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("release_lat", k, 3);
    repeat (2) @(posedge clk);
    #1 chk_idle = 1'b1;
    @(posedge clk);
    #1 chk_idle = 1'b0;
  endtask

  task automatic do_cycle(input bit r,
                          input logic [1:0] a,
                          input logic [7:0] d,
                          input bit busy);
    int lat, p0, w0, ep, ew;
    tx_busy = busy;
    ep = 0; ew = 0;
    exp_rd = r;
    if (r) begin
      case (a)
        2'd0: begin
          exp_dout = (q.size() > 0) ? q[0] : 8'h00;
          ep = (q.size() > 0) ? 1 : 0;
        end
        2'd1: begin
          exp_dout = {5'b0, m_ovr, busy, (q.size() > 0)};
          m_ovr = 1'b0;
        end
        2'd2:    exp_dout = m_ctrl;
        default: exp_dout = 8'h00;
      endcase
    end else begin
      if (a == 2'd0) begin
        if (busy) m_ovr = 1'b1;
        else begin m_txd = d; ew = 1; end
      end else if (a == 2'd2) begin
        m_ctrl = d;
      end
    end
    p0 = n_pop; w0 = n_wr;
    begin_cycle(r, a, d, lat);
    last_lat = lat;
    chk("latency", lat, LAT);
    chk_ack = 1'b1;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 chk_ack = 1'b0;
    end_cycle();
    chk("pops", n_pop - p0, ep);
    chk("writes", n_wr - w0, ew);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, p0, w0, k;
    reset = 1'b1; cs_n = 1'b1; ds_n = 1'b1; rw = 1'b1;
    addr = 2'd0; d_in = 8'h00; tx_busy = 1'b0;
    rx_update();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", d_out, 8'h00);
    chk("rst_doe", d_oe, 0);
    chk("rst_dtack", dtack_n, 1);
    chk("rst_pop", rx_pop, 0);
    chk("rst_wr", tx_wr, 0);
    chk("rst_txdata", tx_data, 8'h00);
    chk("rst_ctrl", ctrl, 8'h00);
    chk("rst_irq", irq, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    q.push_back(8'hA5); rx_update();
    do_cycle(1'b1, 2'd0, 8'h00, 1'b0);
    chk("lit_rd_a5", got_dout, 8'hA5);
    chk("lit_latency", last_lat, 5);

    do_cycle(1'b1, 2'd0, 8'h00, 1'b0);
    chk("lit_rd_empty", got_dout, 8'h00);

    do_cycle(1'b0, 2'd0, 8'h3C, 1'b0);
    chk("lit_txdata", tx_data, 8'h3C);
    do_cycle(1'b0, 2'd0, 8'h99, 1'b1);
    do_cycle(1'b1, 2'd1, 8'h00, 1'b1);
    chk("lit_status_ovr", got_dout, 8'h06);
    do_cycle(1'b1, 2'd1, 8'h00, 1'b0);
    chk("lit_status_clr", got_dout, 8'h00);

    do_cycle(1'b0, 2'd2, 8'h81, 1'b0);
    do_cycle(1'b1, 2'd2, 8'h00, 1'b0);
    chk("lit_ctrl", got_dout, 8'h81);
    q.push_back(8'h5A); rx_update();
    repeat (2) @(posedge clk);
    #1;
`ifdef IRQ_EN
    chk("lit_irq_set", irq, 1);
`endif
    do_cycle(1'b1, 2'd0, 8'h00, 1'b0);
    chk("lit_rd_5a", got_dout, 8'h5A);
`ifdef IRQ_EN
    chk("lit_irq_clr", irq, 0);
`endif

    // Strobe pulse too short to reach the access cycle.
    q.push_back(8'h77); rx_update();
    p0 = n_pop; w0 = n_wr;
    cs_n = 1'b0; ds_n = 1'b0; rw = 1'b1; addr = 2'd0;
    @(posedge clk); @(posedge clk);
    #1 cs_n = 1'b1; ds_n = 1'b1;
    k = 0;
    repeat (12) begin
      @(negedge clk);
      if (dtack_n !== 1'b1) k++;
    end
    chk("abort_dtack", k, 0);
    chk("abort_pops", n_pop - p0, 0);
    chk("abort_wr", n_wr - w0, 0);
    @(posedge clk); #1;
    do_cycle(1'b1, 2'd0, 8'h00, 1'b0);
    chk("lit_after_abort", got_dout, 8'h77);

    do_cycle(1'b0, 2'd0, 8'h12, 1'b1);
    do_cycle(1'b0, 2'd2, 8'h43, 1'b0);
    begin_cycle(1'b1, 2'd2, 8'h00, lat);
    chk("rst_ack_lat", lat, LAT);
    reset = 1'b1; cs_n = 1'b1; ds_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ack_dtack", dtack_n, 1);
    chk("rst_ack_doe", d_oe, 0);
    chk("rst_ack_ctrl", ctrl, 8'h00);
    chk("rst_ack_irq", irq, 0);
    reset = 1'b0;
    m_ctrl = 8'h00; m_ovr = 1'b0; m_txd = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    do_cycle(1'b1, 2'd1, 8'h00, 1'b0);
    chk("lit_rst_status", got_dout, 8'h00);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        q.push_back(8'($urandom));
        rx_update();
      end
      do_cycle(1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)),
               8'($urandom),
               1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
